// File: rtl/dtw_result_packer_if.sv
// Sink-FIFO read port plus AXI-Stream output of the DTW result packer.
// master = packer side, slave = FIFO/DMA side.
interface dtw_result_packer_if;
    logic        fifo_rden;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport master (
        output fifo_rden,
        input  fifo_empty,
        input  fifo_data,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport slave (
        input  fifo_rden,
        output fifo_empty,
        output fifo_data,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );
endinterface

// File: rtl/dtw_result_packer.sv
// Drains 3-word DTW result records from the sink FIFO, tags hit/miss
// against a threshold and emits each record as a 3-beat AXIS packet.
module dtw_result_packer #(
    parameter int AXIS_WIDTH = 32,
    parameter int WIDTH      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [WIDTH-1:0]    threshold,
    input  logic                clear_counts,
    output logic [31:0]         hit_count,
    output logic [31:0]         rec_count,
    output logic                busy,
    dtw_result_packer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_CAP,
        S_SEND
    } state_t;

    state_t                state;
    logic [1:0]            idx;
    logic [1:0]            beat;
    logic [AXIS_WIDTH-1:0] rec_buf [3];

    logic                  more;
    logic                  fire;
    logic                  done;
    logic [WIDTH-1:0]      minval;
    logic                  is_hit;
    logic [AXIS_WIDTH-1:0] word2;

    assign more   = enable && !bus.fifo_empty;
    assign fire   = bus.m_axis_tvalid && bus.m_axis_tready;
    assign done   = (state == S_SEND) && fire && (beat == 2'd2);
    assign minval = bus.fifo_data[WIDTH-1:0];
    assign is_hit = (minval < threshold);

    // Hit flag rides in the MSB of the last beat; the rest is zero-padded.
    assign word2 = {is_hit, {(AXIS_WIDTH-1-WIDTH){1'b0}}, minval};

    // Non-FWFT FIFO: read in REQ, data is on the bus during CAP.
    assign bus.fifo_rden = (state == S_RD_REQ) && !bus.fifo_empty;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            idx               <= '0;
            beat              <= '0;
            rec_buf[0]        <= '0;
            rec_buf[1]        <= '0;
            rec_buf[2]        <= '0;
            bus.m_axis_tdata  <= '0;
            bus.m_axis_tvalid <= 1'b0;
            bus.m_axis_tlast  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (more) begin
                        idx   <= '0;
                        state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!bus.fifo_empty) begin
                        state <= S_RD_CAP;
                    end
                end
                S_RD_CAP: begin
                    if (idx == 2'd2) begin
                        rec_buf[2]        <= word2;
                        idx               <= '0;
                        beat              <= '0;
                        bus.m_axis_tdata  <= rec_buf[0];
                        bus.m_axis_tvalid <= 1'b1;
                        bus.m_axis_tlast  <= 1'b0;
                        state             <= S_SEND;
                    end else begin
                        rec_buf[idx] <= bus.fifo_data;
                        idx          <= idx + 2'd1;
                        state        <= S_RD_REQ;
                    end
                end
                S_SEND: begin
                    if (fire) begin
                        if (beat == 2'd2) begin
                            beat              <= '0;
                            bus.m_axis_tdata  <= '0;
                            bus.m_axis_tvalid <= 1'b0;
                            bus.m_axis_tlast  <= 1'b0;
                            // Chain straight into the next record.
                            if (more) begin
                                idx   <= '0;
                                state <= S_RD_REQ;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            beat             <= beat + 2'd1;
                            bus.m_axis_tdata <= rec_buf[beat + 2'd1];
                            bus.m_axis_tlast <= (beat == 2'd1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Clear has priority over a completing record.
    always_ff @(posedge clk) begin
        if (rst || clear_counts) begin
            hit_count <= '0;
            rec_count <= '0;
        end else if (done) begin
            rec_count <= rec_count + 32'd1;
            hit_count <= hit_count + {31'b0, rec_buf[2][AXIS_WIDTH-1]};
        end
    end

endmodule

// File: doc/dtw_result_packer.md
Name: dtw_result_packer

Overview:
- Downstream stage of the DTW core. Drains the core's sink FIFO, which holds 3-word result records: word0 = query id, word1 = best position, word2 = {16'b0, minval}.
- Classifies each record as hit or miss against a programmable threshold.
- Emits each record as a 3-beat AXI-Stream packet to the DMA, and keeps hit and record counters for the control registers.

Parameters:
- AXIS_WIDTH, 32, output stream data width; fixed at 32.
- WIDTH, 16, minval width carried in word2[WIDTH-1:0].

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  when 0, no new FIFO reads are issued; a record already in progress completes
- threshold  in  16  hit when minval < threshold (unsigned); sampled when word2 is captured
- clear_counts  in  1  one-cycle pulse that zeroes both counters
- fifo_rden  out  1  sink FIFO read enable
- fifo_empty  in  1  sink FIFO empty
- fifo_data  in  32  sink FIFO data, valid the cycle after fifo_rden (standard FIFO, not FWFT)
- m_axis_tdata  out  32  output data
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  high on beat 2 of each record
- hit_count  out  32  records classified as hit since reset/clear
- rec_count  out  32  records emitted since reset/clear
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: fifo_rden=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, hit_count=0, rec_count=0, busy=0. Internal word index=0, record buffer cleared, state=IDLE.
- FSM states: IDLE, RD_REQ, RD_CAP, SEND.
- IDLE:
  - If enable && !fifo_empty: go to RD_REQ with word index=0.
- RD_REQ:
  - If !fifo_empty: assert fifo_rden for exactly one cycle, then go to RD_CAP.
  - If fifo_empty: wait in RD_REQ with rden=0.
  - A record may be split across FIFO refills; reads resume from the current word index.
- RD_CAP:
  - Capture fifo_data into buf[index].
  - On index 2, compute hit = (fifo_data[15:0] < threshold), then go to SEND with beat=0.
  - Otherwise increment index and return to RD_REQ.
- Read rate: at most one read per 2 cycles. The same FIFO word is never read twice.
- SEND:
  - Drive m_axis_tdata = buf[beat] with tvalid=1.
  - Beat 2 data is {hit, 15'b0, minval[15:0]}; the upper zero bits of the input word are replaced by this layout.
  - tlast = (beat==2).
  - Beat advances only on tvalid && tready. tdata, tvalid and tlast stay stable while tready=0 (AXIS rule).
  - After beat 2 handshakes: rec_count += 1; hit_count += hit. Then go to IDLE, or directly to RD_REQ if enable && !fifo_empty.
- Latency: the first tvalid rises 7 cycles after empty deasserts from IDLE (IDLE→REQ, 3×REQ/CAP pairs, SEND registered). Tolerance is ±0 cycles; the bench checks exactly.
- clear_counts:
  - Zeroes both counters in the same cycle it is high.
  - If it coincides with a record-complete increment, clear wins and the counters read 0.
- Counters wrap at 2^32 with no saturation.
- enable deasserted mid-record: the current record is fully read and sent. There is no partial packet, ever.
- rst mid-record: everything returns to reset values next cycle. Partially read words are lost, and the core and FIFO are expected to be cleared by the same reset.
- threshold changes mid-record: only the value in the RD_CAP cycle of word 2 matters.
- threshold = 0: never a hit. threshold = 16'hFFFF: hit unless minval = 16'hFFFF.

Test Plan:
- Single record, tready=1: FIFO holds {0x00000007, 0x00001234, 0x000000A0}, threshold=0x0100 → beats 0x7, 0x1234, 0x800000A0; tlast on beat 2 only; hit_count=1, rec_count=1; first tvalid 7 cycles after empty falls.
- Miss case: minval=0x0100, threshold=0x0100 → beat2 = 0x00000100; hit_count stays 0; rec_count=1.
- Backpressure: tready low for 5 cycles on beat 1 → tdata holds 0x1234 with tvalid=1 throughout; there are no duplicate or missing beats and no extra FIFO reads.
- Split record: FIFO empties after word 1 for 10 cycles → fifo_rden stays 0 and no tvalid appears; after the refill, the packet is correct and contiguous.
- Back-to-back: 4 records preloaded, enable=1, tready=1 → 12 beats with 4 tlast pulses; the record from IDLE→SEND has no IDLE gap between records; rec_count=4.
- Corner events: clear_counts in the same cycle as the beat-2 handshake → counters 0. Also deassert enable after word 1 → the record still completes and no new read follows. Then assert rst during SEND → tvalid=0 next cycle and counters=0.
